// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operation codes and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_PASS_B = 2'b10;
  localparam logic [1:0] OP_NEG_B  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: full adder with gated A input and invertible B input.
module alu1bit (
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic aen,
  input  logic binv,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic a_eff;
  logic b_eff;

  assign a_eff = a & aen;
  assign b_eff = b ^ binv;
  assign sum   = ~reset & (a_eff ^ b_eff ^ cin);
  assign cout  = ~reset & ((a_eff & b_eff) | (cin & (a_eff ^ b_eff)));

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds operand bits LSB first into an external alu1bit slice
// and collects the sum bits, final carry and signed overflow.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             overflow,
  output logic             alu_reset,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_aen,
  output logic             alu_binv,
  output logic             alu_cin,
  input  logic             alu_sum,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             ovf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      op_reg     <= OP_ADD;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sr_reg   <= a_in;
            b_sr_reg   <= b_in;
            op_reg     <= op;
            cnt_reg    <= '0;
            carry_reg  <= op[0];  // +1 completes the two's complement of B
            result_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_reg <= {alu_sum, result_reg[WIDTH-1:1]};
          carry_reg  <= alu_cout;
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            // alu_cin here is the carry into the MSB
            cout_reg  <= alu_cout;
            ovf_reg   <= alu_cin ^ alu_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // busy_reg is high exactly in RUN, so it gates the slice controls
  assign alu_reset = reset;
  assign alu_a     = busy_reg & a_sr_reg[0];
  assign alu_b     = busy_reg & b_sr_reg[0];
  assign alu_aen   = busy_reg & ~op_reg[1];
  assign alu_binv  = busy_reg & op_reg[0];
  assign alu_cin   = busy_reg & carry_reg;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign cout_out = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer that drives a single `alu1bit` slice to perform WIDTH-bit add, subtract, pass and negate operations. It latches the operands on `start` and presents one bit pair per cycle, LSB first, with the carry held in a flop between cycles. It shifts the slice's sum back into a result register and reports the carry-out and signed overflow. It sits between a requesting datapath and the `alu1bit` instance in the parent module.

## Interface
Clock is `clk`; reset is `reset`, synchronous and active-high. Both are fixed.

Parameters:
- `WIDTH`, default 8: operand and result width in bits; minimum 2.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: operation code: 00 ADD, 01 SUB, 10 PASS_B, 11 NEG_B.
- `a_in` in WIDTH: operand A, latched on an accepted `start`.
- `b_in` in WIDTH: operand B, latched on an accepted `start`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out WIDTH: final result; held until the next accepted `start`.
- `cout_out` out 1: carry out of the MSB.
- `overflow` out 1: signed overflow, computed as carry into the MSB XOR carry out of the MSB.
- `alu_reset` out 1: equal to `reset`.
- `alu_a` out 1: slice input a.
- `alu_b` out 1: slice input b.
- `alu_aen` out 1: slice input aen.
- `alu_binv` out 1: slice input binv.
- `alu_cin` out 1: slice input cin.
- `alu_sum` in 1: slice sum, combinational from the slice inputs.
- `alu_cout` in 1: slice carry-out, combinational from the slice inputs.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- Accepted `start` (IDLE only) performs all of the following at once:
  - latches `a_in`, `b_in` into shift registers and `op` into an op register;
  - clears the bit counter;
  - loads the carry flop with `op[0]` (1 for SUB and NEG_B);
  - clears `result`.
- Slice control during RUN:
  - `alu_aen` = ~`op[1]`;
  - `alu_binv` = `op[0]`;
  - `alu_a` = A shift register [0];
  - `alu_b` = B shift register [0];
  - `alu_cin` = carry flop.
- Slice control outside RUN: all `alu_*` data and control outputs are 0.
- Each RUN cycle:
  - `result` shifts right with `alu_sum` entering the MSB;
  - carry flop ← `alu_cout`;
  - A and B shift right;
  - counter increments.
- On the last RUN cycle:
  - `cout_out` ← `alu_cout`;
  - `overflow` ← `alu_cin` ^ `alu_cout`.
- `start` is ignored in RUN and DONE; there is no queueing.
- Arithmetic is modulo 2^WIDTH. SUB produces A + ~B + 1, so `cout_out` = 1 means no borrow.
- Reset at any time, including mid-RUN:
  - next state is IDLE;
  - any in-flight operation is discarded;
  - no `done` pulse.

## Timing
- If `start` is accepted at edge k:
  - RUN occupies cycles k+1 through k+WIDTH;
  - `done` is high during cycle k+WIDTH+1 only.
- Latency from `start` to `done` is WIDTH+1 cycles. Minimum start-to-start spacing is WIDTH+2 cycles.
- `result`, `cout_out` and `overflow` become valid in the `done` cycle and stay stable until the next accepted `start`.
- `busy` is high exactly during the WIDTH RUN cycles.
- Reset values:
  - `busy`, `done`, `result`, `cout_out`, `overflow` are all 0;
  - all `alu_*` outputs are 0 except `alu_reset`, which follows `reset`.
- The slice path (`alu_a`/`alu_b`/`alu_cin` → `alu_sum`/`alu_cout` → flops) is a single-cycle combinational path.

## Structure
- Shared package `alu_pkg` holds:
  - op encodings `OP_ADD`, `OP_SUB`, `OP_PASS_B`, `OP_NEG_B`;
  - FSM state encodings `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- The counter width is `$clog2(WIDTH)`.
- No sub-module. `alu1bit` is instantiated beside this block by the parent, not inside it.
- Benches instantiate `alu_serial_ctrl` and `alu1bit` together.

## Test plan
All scenarios use WIDTH=8.
- ADD 8'h3C + 8'h05 → `result` 8'h41, `cout_out` 0, `overflow` 0; `done` exactly 9 cycles after `start`; `busy` high for 8 cycles.
- SUB 8'h05 − 8'h06 → 8'hFF, `cout_out` 0, `overflow` 0. Then SUB 8'h80 − 8'h01 → 8'h7F, `cout_out` 1, `overflow` 1.
- ADD 8'h7F + 8'h01 → 8'h80, `overflow` 1. ADD 8'hFF + 8'h01 → 8'h00, `cout_out` 1, `overflow` 0.
- PASS_B with `a_in` 8'hAA, `b_in` 8'h5C → 8'h5C, with `alu_aen` 0 throughout RUN. NEG_B with `b_in` 8'h01 → 8'hFF.
- `start` pulsed with different operands at RUN cycle 3 → ignored; the first operation's result is unchanged.
- `reset` asserted at RUN cycle 4 → next cycle in IDLE with all outputs 0 and no `done` pulse. A following ADD 8'h01 + 8'h01 → 8'h02.
